// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-sequencer bus: hazard/redirect/halt controls in, PC and fetch status out.
// The pipeline side is the master; the fetch sequencer is the slave.
interface fetch_pc_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              stall_i;
  logic              branch_taken_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              jump_i;
  logic [ADDR_W-1:0] jump_target_i;
  logic              halt_i;
  logic              resume_i;
  logic [ADDR_W-1:0] pc_o;
  logic [1:0]        pc_sel_o;
  logic              flush_o;
  logic              fetch_valid_o;
  logic [1:0]        state_o;

  modport master (
    output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
           halt_i, resume_i,
    input  pc_o, pc_sel_o, flush_o, fetch_valid_o, state_o
  );

  modport slave (
    input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
           halt_i, resume_i,
    output pc_o, pc_sel_o, flush_o, fetch_valid_o, state_o
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// IF-stage fetch sequencer: owns the PC, picks the next-PC source, buffers
// redirects that arrive while stalled, and implements halt/resume.
module fetch_pc_ctrl #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
  input logic           clk,
  input logic           rst_n,
  fetch_pc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_JMP = 2'd2;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] pend_target, pend_target_nxt;
  logic [1:0]        pend_sel, pend_sel_nxt;
  logic [1:0]        pc_sel;
  logic              flush, fetch_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pend_target <= '0;
      pend_sel    <= SEL_SEQ;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_target <= pend_target_nxt;
      pend_sel    <= pend_sel_nxt;
    end
  end

  // A branch always outranks a jump: the jump is younger and thus wrong-path.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pend_target_nxt = pend_target;
    pend_sel_nxt    = pend_sel;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (bus.branch_taken_i || bus.jump_i) begin
          if (bus.stall_i) begin
            state_nxt       = PEND;
            pend_target_nxt = bus.branch_taken_i ? bus.branch_target_i : bus.jump_target_i;
            pend_sel_nxt    = bus.branch_taken_i ? SEL_BR : SEL_JMP;
          end else begin
            pc_nxt = bus.branch_taken_i ? bus.branch_target_i : bus.jump_target_i;
          end
        end else if (!bus.stall_i) begin
          if (bus.halt_i) state_nxt = HALT;
          else            pc_nxt    = pc + PC_STEP;
        end
      end
      PEND: begin
        if (bus.stall_i) begin
          if (bus.branch_taken_i) begin
            pend_target_nxt = bus.branch_target_i;
            pend_sel_nxt    = SEL_BR;
          end else if (bus.jump_i && pend_sel == SEL_JMP) begin
            pend_target_nxt = bus.jump_target_i;
          end
        end else begin
          pc_nxt          = bus.branch_taken_i ? bus.branch_target_i : pend_target;
          pend_target_nxt = '0;
          pend_sel_nxt    = SEL_SEQ;
          state_nxt       = RUN;
        end
      end
      HALT: if (bus.resume_i) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    pc_sel      = SEL_SEQ;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    case (state)
      RUN: begin
        if (!bus.stall_i) begin
          if (bus.branch_taken_i) begin
            pc_sel = SEL_BR;
            flush  = 1'b1;
          end else if (bus.jump_i) begin
            pc_sel = SEL_JMP;
            flush  = 1'b1;
          end else if (!bus.halt_i) begin
            fetch_valid = 1'b1;
          end
        end
      end
      PEND: begin
        if (!bus.stall_i) begin
          flush  = 1'b1;
          pc_sel = bus.branch_taken_i ? SEL_BR : pend_sel;
        end
      end
      default: ;
    endcase
  end

  assign bus.pc_o          = pc;
  assign bus.pc_sel_o      = pc_sel;
  assign bus.flush_o       = flush;
  assign bus.fetch_valid_o = fetch_valid;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus random traffic, all checked
// against a redirect-queue model of the fetch rules; a second 8-bit instance checks PC wrap.
module tb_fetch_pc_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.ADDR_W(32)) bus ();
  fetch_pc_ctrl_if #(.ADDR_W(8))  wbus ();

  fetch_pc_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  fetch_pc_ctrl #(.ADDR_W(8), .RESET_PC(8'hF8), .PC_STEP(8'd4)) wdut (
    .clk(clk), .rst_n(rst_n), .bus(wbus)
  );

  typedef struct {
    logic [31:0] target;
    int          kind;
  } redirect_t;

  int          checkCount = 0;
  int          failCount  = 0;
  int          mState;
  logic [31:0] mPc;
  redirect_t   pendQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mState = 0;
    mPc    = 32'h0;
    pendQ.delete();
  endtask

  // Drives one cycle of inputs, checks outputs against the model, then clocks.
  task automatic applyStimulus(input bit st, input bit br, input logic [31:0] bt,
                               input bit jp, input logic [31:0] jt,
                               input bit hl, input bit rs);
    int          eSel, nState;
    bit          eFlush, eValid;
    logic [31:0] nPc;
    bus.stall_i         = st;
    bus.branch_taken_i  = br;
    bus.branch_target_i = bt;
    bus.jump_i          = jp;
    bus.jump_target_i   = jt;
    bus.halt_i          = hl;
    bus.resume_i        = rs;
    #1;
    eSel = 0; eFlush = 0; eValid = 0; nState = mState; nPc = mPc;
    case (mState)
      0: nState = 1;
      1: begin
        if (br || jp) begin
          if (!st) begin
            eFlush = 1;
            eSel   = br ? 1 : 2;
            nPc    = br ? bt : jt;
          end else begin
            pendQ.push_back('{br ? bt : jt, br ? 1 : 2});
            nState = 2;
          end
        end else if (!st) begin
          if (hl) nState = 3;
          else begin
            eValid = 1;
            nPc    = mPc + 32'd4;
          end
        end
      end
      2: begin
        if (st) begin
          if (br) pendQ[0] = '{bt, 1};
          else if (jp && pendQ[0].kind == 2) pendQ[0] = '{jt, 2};
        end else begin
          eFlush = 1;
          if (br) begin
            eSel = 1;
            nPc  = bt;
          end else begin
            eSel = pendQ[0].kind;
            nPc  = pendQ[0].target;
          end
          pendQ.delete();
          nState = 1;
        end
      end
      default: if (rs) nState = 1;
    endcase
    checkOutput("pc", bus.pc_o, mPc);
    checkOutput("state", 32'(bus.state_o), 32'(mState));
    checkOutput("pc_sel", 32'(bus.pc_sel_o), 32'(eSel));
    checkOutput("flush", 32'(bus.flush_o), 32'(eFlush));
    checkOutput("fetch_valid", 32'(bus.fetch_valid_o), 32'(eValid));
    @(posedge clk);
    #1;
    mState = nState;
    mPc    = nPc;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pc"}, bus.pc_o, 32'h0);
    checkOutput({tag, "_state"}, 32'(bus.state_o), 32'd0);
    checkOutput({tag, "_sel"}, 32'(bus.pc_sel_o), 32'd0);
    checkOutput({tag, "_flush"}, 32'(bus.flush_o), 32'd0);
    checkOutput({tag, "_valid"}, 32'(bus.fetch_valid_o), 32'd0);
  endtask

  initial begin
    logic [7:0] wrapExp [5];
    wrapExp = '{8'hF8, 8'hF8, 8'hFC, 8'h00, 8'h04};
    bus.stall_i = 0; bus.branch_taken_i = 0; bus.branch_target_i = '0;
    bus.jump_i = 0; bus.jump_target_i = '0; bus.halt_i = 0; bus.resume_i = 0;
    wbus.stall_i = 0; wbus.branch_taken_i = 0; wbus.branch_target_i = '0;
    wbus.jump_i = 0; wbus.jump_target_i = '0; wbus.halt_i = 0; wbus.resume_i = 0;

    $display("[TB] reset and boot");
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    checkOutput("wrap_reset_pc", 32'(wbus.pc_o), 32'hF8);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("wrap_pc", 32'(wbus.pc_o), 32'(wrapExp[i]));
      idle();
    end
    checkOutput("boot_pc_after", bus.pc_o, 32'h10);

    $display("[TB] branch and jump together");
    applyStimulus(0, 1, 32'h100, 1, 32'h200, 0, 0);
    checkOutput("br_win_pc", bus.pc_o, 32'h100);
    idle();
    idle();
    checkOutput("br_win_seq", bus.pc_o, 32'h108);

    $display("[TB] redirect during stall");
    applyStimulus(1, 0, 32'h0, 1, 32'h40, 0, 0);
    applyStimulus(1, 1, 32'h80, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1, 0);
    checkOutput("pend_frozen_pc", bus.pc_o, 32'h108);
    idle();
    checkOutput("pend_apply_pc", bus.pc_o, 32'h80);
    idle();

    $display("[TB] halt and resume");
    applyStimulus(0, 0, 32'h0, 1, 32'h20, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0);
    applyStimulus(0, 1, 32'h300, 0, 32'h0, 1, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1);
    checkOutput("resume_pc", bus.pc_o, 32'h20);
    idle();
    idle();
    checkOutput("resume_seq", bus.pc_o, 32'h28);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom,
                    $urandom_range(0, 5) == 0, $urandom,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] async reset while pending");
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1);
    applyStimulus(1, 0, 32'h0, 1, 32'h500, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0);
    checkOutput("pend_before_reset", 32'(bus.state_o), 32'd2);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    checkOutput("no_stale_redirect", bus.pc_o, 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
